display_address_gen: RTL and testbench

Parametrised display-address generator producing the DA bus for the MC6847X video core. Consumes per-byte fetch strobes (data preload) and line/frame pulses from frame timing. Walks video memory with the row-repeat factor and bytes-per-row set by the current graphics or alpha mode. Also exports the sub-row index used by the alpha character generator.

---
 rtl/dag_pkg.sv | 43 ++++
 rtl/display_address_gen_if.sv | 36 +++
 rtl/dag_mode_decode.sv | 21 ++
 rtl/display_address_gen.sv | 110 +++++++++++
 tb/tb_display_address_gen.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dag_pkg.sv
// Shared definitions for the display address generator.
//   - mode encoding constants ({ag, gm[2:0]})
//   - per-mode geometry lookup (bytes per row, scanline divisor)
//   - default scanlines per alpha text row
package dag_pkg;

    localparam logic [3:0] MODE_ALPHA = 4'b0000;
    localparam logic [3:0] GM0        = 4'b1000;
    localparam logic [3:0] GM1        = 4'b1001;
    localparam logic [3:0] GM2        = 4'b1010;
    localparam logic [3:0] GM3        = 4'b1011;
    localparam logic [3:0] GM4        = 4'b1100;
    localparam logic [3:0] GM5        = 4'b1101;
    localparam logic [3:0] GM6        = 4'b1110;
    localparam logic [3:0] GM7        = 4'b1111;

    localparam int DEFAULT_ALPHA_DIV = 12;

    typedef struct packed {
        logic [5:0] bpr;  // bytes fetched per displayed row (16 or 32)
        logic [3:0] div;  // scanlines each row is repeated for
    } dag_geom_t;

    // Alpha ignores gm entirely; graphics modes use a fixed table.
    function automatic dag_geom_t dag_geom(input logic [3:0] mode,
                                           input logic [3:0] alpha_div);
        dag_geom_t g;
        if (!mode[3]) begin
            g = '{bpr: 6'd32, div: alpha_div};
        end else begin
            case (mode[2:0])
                3'd0, 3'd1: g = '{bpr: 6'd16, div: 4'd3};
                3'd2:       g = '{bpr: 6'd32, div: 4'd3};
                3'd3:       g = '{bpr: 6'd16, div: 4'd2};
                3'd4:       g = '{bpr: 6'd32, div: 4'd2};
                3'd5:       g = '{bpr: 6'd16, div: 4'd1};
                default:    g = '{bpr: 6'd32, div: 4'd1};
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/display_address_gen_if.sv
// Bus between frame timing (master) and the display address generator (slave).
//   master drives: mode, base_addr, frame_start, line_start, fetch
//   slave drives:  da, sub_row, row_last, overrun (only with DAG_OVERRUN_EN)
interface display_address_gen_if #(
    parameter int ADDR_W = 13
);
    logic [3:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic              frame_start;
    logic              line_start;
    logic              fetch;
    logic [ADDR_W-1:0] da;
    logic [3:0]        sub_row;
    logic              row_last;
`ifdef DAG_OVERRUN_EN
    logic              overrun;

    modport master (
        output mode, base_addr, frame_start, line_start, fetch,
        input  da, sub_row, row_last, overrun
    );
    modport slave (
        input  mode, base_addr, frame_start, line_start, fetch,
        output da, sub_row, row_last, overrun
    );
`else
    modport master (
        output mode, base_addr, frame_start, line_start, fetch,
        input  da, sub_row, row_last
    );
    modport slave (
        input  mode, base_addr, frame_start, line_start, fetch,
        output da, sub_row, row_last
    );
`endif
endinterface

// File: rtl/dag_mode_decode.sv
// Combinational geometry decode for the latched display mode.
//   mode_q        in  4  latched {ag, gm[2:0]}
//   bytes_per_row out 6  bytes fetched per row
//   divisor       out 4  scanlines per repeated row
module dag_mode_decode
    import dag_pkg::*;
#(
    parameter int ALPHA_DIV = DEFAULT_ALPHA_DIV
) (
    input  logic [3:0] mode_q,
    output logic [5:0] bytes_per_row,
    output logic [3:0] divisor
);
    dag_geom_t geom;

    always_comb begin
        geom          = dag_geom(mode_q, 4'(ALPHA_DIV));
        bytes_per_row = geom.bpr;
        divisor       = geom.div;
    end
endmodule

// File: rtl/display_address_gen.sv
// Display address generator for the MC6847X video core.
// Walks video memory one byte per fetch strobe, repeating each row for the
// mode's scanline divisor, and exports the sub-row index for the character
// generator.
//   clk      in   video clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport: mode/base_addr/frame_start/line_start/fetch in,
//            da/sub_row/row_last (and overrun) out
// Optional feature: define DAG_OVERRUN_EN to add the sticky overrun flag.
module display_address_gen
    import dag_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int ALPHA_DIV = DEFAULT_ALPHA_DIV
) (
    input  logic                  clk,
    input  logic                  reset_n,
    display_address_gen_if.slave  bus
);
    logic [3:0]        mode_q,     mode_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] da_q,       da_d;
    logic [5:0]        byte_cnt_q, byte_cnt_d;
    logic [3:0]        sub_row_q,  sub_row_d;
    logic [5:0]        bytes_per_row;
    logic [3:0]        divisor;
    logic              last_sub_row;
`ifdef DAG_OVERRUN_EN
    logic              overrun_q,  overrun_d;
`endif

    dag_mode_decode #(.ALPHA_DIV(ALPHA_DIV)) u_mode_decode (
        .mode_q        (mode_q),
        .bytes_per_row (bytes_per_row),
        .divisor       (divisor)
    );

    assign last_sub_row = (sub_row_q == divisor - 4'd1);

    // Priority: frame_start > line_start > fetch.
    always_comb begin
        mode_d     = mode_q;
        row_base_d = row_base_q;
        da_d       = da_q;
        byte_cnt_d = byte_cnt_q;
        sub_row_d  = sub_row_q;
`ifdef DAG_OVERRUN_EN
        overrun_d  = overrun_q;
`endif
        if (bus.frame_start) begin
            mode_d     = bus.mode;
            da_d       = bus.base_addr;
            row_base_d = bus.base_addr;
            byte_cnt_d = '0;
            sub_row_d  = '0;
`ifdef DAG_OVERRUN_EN
            overrun_d  = 1'b0;
`endif
        end else if (bus.line_start) begin
            byte_cnt_d = '0;
            if (last_sub_row) begin
                // da already points past the row just shown
                sub_row_d  = '0;
                row_base_d = da_q;
            end else begin
                sub_row_d  = sub_row_q + 4'd1;
                da_d       = row_base_q;
            end
        end else if (bus.fetch) begin
            if (byte_cnt_q < bytes_per_row) begin
                da_d       = da_q + ADDR_W'(1);
                byte_cnt_d = byte_cnt_q + 6'd1;
            end
`ifdef DAG_OVERRUN_EN
            else begin
                overrun_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= MODE_ALPHA;
            row_base_q <= '0;
            da_q       <= '0;
            byte_cnt_q <= '0;
            sub_row_q  <= '0;
`ifdef DAG_OVERRUN_EN
            overrun_q  <= 1'b0;
`endif
        end else begin
            mode_q     <= mode_d;
            row_base_q <= row_base_d;
            da_q       <= da_d;
            byte_cnt_q <= byte_cnt_d;
            sub_row_q  <= sub_row_d;
`ifdef DAG_OVERRUN_EN
            overrun_q  <= overrun_d;
`endif
        end
    end

    assign bus.da       = da_q;
    assign bus.sub_row  = sub_row_q;
    assign bus.row_last = last_sub_row;
`ifdef DAG_OVERRUN_EN
    assign bus.overrun  = overrun_q;
`endif
endmodule

// File: tb/tb_display_address_gen.sv
// Self-checking bench for display_address_gen (ADDR_W=13, ALPHA_DIV=12).
// A line/row-level model predicts da, sub_row, row_last (and overrun) and is
// compared against the DUT on every falling clock edge; directed checks with
// literal values pin the model at the points of interest.
module tb_display_address_gen;
    localparam int ADDR_W    = 13;
    localparam int ALPHA_DIV = 12;
    localparam int MASK      = (1 << ADDR_W) - 1;

    logic clk;
    logic reset_n;

    display_address_gen_if #(.ADDR_W(ADDR_W)) bus ();

    display_address_gen #(.ADDR_W(ADDR_W), .ALPHA_DIV(ALPHA_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: row start address, line index within frame, fetches seen this line.
    int m_mode = 0;
    int m_row  = 0;
    int m_line = 0;
    int m_f    = 0;
    int m_ovr  = 0;

    int BPR_GM[8] = '{16, 16, 32, 16, 32, 16, 32, 32};
    int DIV_GM[8] = '{ 3,  3,  3,  2,  2,  1,  1,  1};

    function automatic int geo_bpr(input int md);
        return (md < 8) ? 32 : BPR_GM[md - 8];
    endfunction

    function automatic int geo_div(input int md);
        return (md < 8) ? ALPHA_DIV : DIV_GM[md - 8];
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int exp_da();
        return (m_row + min2(m_f, geo_bpr(m_mode))) & MASK;
    endfunction

    function automatic int exp_sub();
        return m_line % geo_div(m_mode);
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_row = 0; m_line = 0; m_f = 0; m_ovr = 0;
    endfunction

    function automatic void model_update(input bit fs, input bit ls, input bit fe);
        if (fs) begin
            m_mode = int'(bus.mode);
            m_row  = int'(bus.base_addr);
            m_line = 0;
            m_f    = 0;
            m_ovr  = 0;
        end else if (ls) begin
            if (exp_sub() == geo_div(m_mode) - 1)
                m_row = (m_row + min2(m_f, geo_bpr(m_mode))) & MASK;
            m_line++;
            m_f = 0;
        end else if (fe) begin
            if (m_f >= geo_bpr(m_mode)) m_ovr = 1;
            m_f++;
        end
    endfunction

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("cyc_da",       int'(bus.da),       exp_da());
        chk("cyc_sub_row",  int'(bus.sub_row),  exp_sub());
        chk("cyc_row_last", int'(bus.row_last), (exp_sub() == geo_div(m_mode) - 1) ? 1 : 0);
`ifdef DAG_OVERRUN_EN
        chk("cyc_overrun",  int'(bus.overrun),  m_ovr);
`endif
    end

    task automatic step(input bit fs, input bit ls, input bit fe);
        bus.frame_start = fs;
        bus.line_start  = ls;
        bus.fetch       = fe;
        @(posedge clk);
        if (reset_n) model_update(fs, ls, fe);
        #1;
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.fetch       = 1'b0;
    endtask

    task automatic set_mode(input logic [3:0] md, input logic [ADDR_W-1:0] base);
        bus.mode      = md;
        bus.base_addr = base;
    endtask

    task automatic fetches(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n         = 1'b0;
        bus.mode        = 4'b0000;
        bus.base_addr   = '0;
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.fetch       = 1'b0;
        model_reset();

        // Reset held, then release and fetch without a frame_start.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_da",       int'(bus.da),       0);
        chk("rst_sub_row",  int'(bus.sub_row),  0);
        chk("rst_row_last", int'(bus.row_last), 0);
        reset_n = 1'b1;
        step(0, 0, 0);
        fetches(5);
        chk("post_rst_5_fetch", int'(bus.da), 5);

        // GM6, base 0x0400: 40 fetches capped at 32.
        set_mode(4'b1110, 13'h0400);
        step(1, 0, 0);
        chk("gm6_frame_da", int'(bus.da), 'h0400);
        fetches(40);
        chk("gm6_capped", int'(bus.da), 'h0420);
        step(0, 1, 0);
        chk("gm6_line_da",  int'(bus.da),      'h0420);
        chk("gm6_line_sub", int'(bus.sub_row), 0);
`ifdef DAG_OVERRUN_EN
        chk("gm6_overrun", int'(bus.overrun), 1);
`endif

        // GM1, base 0: rows repeat three times.
        set_mode(4'b1001, 13'h0000);
        step(1, 0, 0);
`ifdef DAG_OVERRUN_EN
        chk("gm1_ovr_clear", int'(bus.overrun), 0);
`endif
        for (int l = 0; l < 4; l++) begin
            chk("gm1_line_start_da", int'(bus.da), (l < 3) ? 'h00 : 'h10);
            chk("gm1_sub_row",       int'(bus.sub_row),  l % 3);
            chk("gm1_row_last",      int'(bus.row_last), (l == 2) ? 1 : 0);
            fetches(16);
            chk("gm1_line_end_da",   int'(bus.da), (l < 3) ? 'h10 : 'h20);
            step(0, 1, 0);
        end

        // Alpha, 12 scanlines per text row.
        set_mode(4'b0000, 13'h0000);
        step(1, 0, 0);
        for (int l = 0; l < 13; l++) begin
            chk("alpha_line_start_da", int'(bus.da),      (l < 12) ? 'h00 : 'h20);
            chk("alpha_sub_row",       int'(bus.sub_row), (l < 12) ? l : 0);
            fetches(32);
            chk("alpha_line_end_da",   int'(bus.da),      (l < 12) ? 'h20 : 'h40);
            step(0, 1, 0);
        end

        // line_start with fetch: fetch dropped, byte count restarts (GM5, div 1).
        set_mode(4'b1101, 13'h0100);
        step(1, 0, 0);
        fetches(3);
        chk("coll_pre", int'(bus.da), 'h103);
        step(0, 1, 1);
        chk("coll_ls_fetch_da",  int'(bus.da),      'h103);
        chk("coll_ls_fetch_sub", int'(bus.sub_row), 0);
        fetches(17);
        chk("coll_cnt_restart", int'(bus.da), 'h113);

        // frame_start with line_start and fetch.
        set_mode(4'b1010, 13'h0050);
        step(1, 1, 1);
        chk("coll_fs_ls_da",  int'(bus.da),      'h050);
        chk("coll_fs_ls_sub", int'(bus.sub_row), 0);

        // Mode input changes mid-frame: GM2 geometry stays in force.
        set_mode(4'b1101, 13'h0000);
        fetches(20);
        chk("midmode_fetch", int'(bus.da), 'h064);
        step(0, 1, 0);
        chk("midmode_rewind_da",  int'(bus.da),      'h050);
        chk("midmode_rewind_sub", int'(bus.sub_row), 1);
        step(1, 0, 0);
        fetches(20);
        chk("newmode_capped", int'(bus.da), 'h010);

        // Address wrap at 2^13.
        set_mode(4'b1111, 13'h1FF0);
        step(1, 0, 0);
        fetches(32);
        chk("wrap_da", int'(bus.da), 'h0010);
        fetches(1);
`ifdef DAG_OVERRUN_EN
        chk("wrap_overrun", int'(bus.overrun), 1);
`endif

        // Asynchronous reset mid-line.
        step(1, 0, 0);
        fetches(7);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_da",  int'(bus.da),      0);
        chk("async_rst_sub", int'(bus.sub_row), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("post_async_da", int'(bus.da), 0);
        set_mode(4'b1011, 13'h0200);
        step(1, 0, 0);
        fetches(16);
        step(0, 1, 0);
        chk("gm3_repeat_sub", int'(bus.sub_row),  1);
        chk("gm3_row_last",   int'(bus.row_last), 1);
        chk("gm3_rewind_da",  int'(bus.da),       'h200);
        step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
